// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: FSM states,
// instruction constants and the IF/ID bundle.
package fetch_stage_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]        pc4;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_pipe_reg_if_id.sv
// IF/ID pipeline register: hold beats squash,
// squash loads a NOP bubble, else load d.
module pipe_reg_if_id
  import fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   hold,
  input  logic   squash,
  input  if_id_t d,
  output if_id_t q
);

  // register with hold/squash priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '{pc4: 32'h0, instr: NOP_INSTR, valid: 1'b0};
    end else if (hold) begin
      q <= q;
    end else if (squash) begin
      q <= '{pc4: 32'h0, instr: NOP_INSTR, valid: 1'b0};
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, run/idle/error FSM, IF/ID
// register and fetch/flush counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [31:0]      offset_i,
  output logic [31:0]      imem_addr_o,
  input  logic [31:0]      imem_data_i,
  output logic [31:0]      if_id_pc4_o,
  output logic [31:0]      if_id_instr_o,
  output logic             if_id_valid_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d, target;
  logic             hold, squash;
  logic             fetch_inc, flush_inc;
  logic [CNT_W-1:0] fetch_cnt_q, flush_cnt_q;
  if_id_t           if_id_d, if_id_q;

  assign target = pc_q + offset_i;

  // next state, next PC and IF/ID control
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold      = 1'b0;
    squash    = 1'b1;
    fetch_inc = 1'b0;
    flush_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!start_i) begin
          state_d = ST_IDLE;
        end else if (stall_i) begin
          hold = 1'b1;
        end else if (flush_i) begin
          pc_d      = target;
          flush_inc = 1'b1;
          if (target[1:0] != 2'b00)
            state_d = ST_ERR;
        end else begin
          pc_d      = pc_q + PC_STEP;
          squash    = 1'b0;
          fetch_inc = 1'b1;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and program counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // saturating performance counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (fetch_inc && fetch_cnt_q != '1)
        fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
      if (flush_inc && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign if_id_d.pc4   = pc_q + PC_STEP;
  assign if_id_d.instr = imem_data_i;
  assign if_id_d.valid = 1'b1;

  pipe_reg_if_id u_if_id (
    .clk    (clk_i),
    .rst    (rst_i),
    .hold   (hold),
    .squash (squash),
    .d      (if_id_d),
    .q      (if_id_q)
  );

  assign imem_addr_o   = pc_q;
  assign if_id_pc4_o   = if_id_q.pc4;
  assign if_id_instr_o = if_id_q.instr;
  assign if_id_valid_o = if_id_q.valid;
  assign misalign_o    = (state_q == ST_ERR);
  assign fetch_cnt_o   = fetch_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule
